// File: rtl/axis_mem_responder.sv
// AXI-Stream to memory-command bridge.
// A header beat selects a burst (start address, length, direction). Write
// bursts pass data beats straight to the memory port; read bursts issue
// memory reads and return the read data on the response stream through a
// small FIFO, tagging the last beat of each burst with tuser.
module axis_mem_responder #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 27,
    parameter int RESP_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,

    input  logic              req_axis_valid,
    input  logic              req_axis_tuser,
    input  logic [DATA_W-1:0] req_axis_data,
    output logic              req_axis_ready,

    output logic              resp_axis_valid,
    output logic              resp_axis_tuser,
    output logic [DATA_W-1:0] resp_axis_data,
    input  logic              resp_axis_ready,

    output logic              mem_valid,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,

    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err_out
);

    localparam int LEN_W = 27;
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              err_q, err_d;

    // Reads issued but not yet returned; tag bit 0 belongs to the oldest one
    // and says whether it is the final beat of its burst.
    logic [CNT_W-1:0]  os_q, os_d;
    logic [RESP_DEPTH:0] tag_q, tag_d;

    // Response FIFO: data plus a last-of-burst flag per entry.
    logic [DATA_W-1:0]     fdata_q [RESP_DEPTH];
    logic [DATA_W-1:0]     fdata_d [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] flast_q, flast_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      fcnt_q, fcnt_d;

    logic [LEN_W-1:0] hdr_len;
    logic             room, last_beat, wr_fire, rd_fire, rsp_push, rsp_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign hdr_len   = req_axis_data[27:1];
    // Reads and buffered responses together never exceed the FIFO, so a
    // returning read always has a slot.
    assign room      = ({1'b0, os_q} + {1'b0, fcnt_q}) < (CNT_W + 1)'(RESP_DEPTH);
    assign last_beat = (beat_q == len_q - LEN_W'(1));
    assign wr_fire   = (state_q == S_WRITE) && req_axis_valid && mem_ready;
    assign rd_fire   = (state_q == S_READ) && room && mem_ready;
    assign rsp_push  = mem_rvalid && (os_q != '0);
    assign rsp_pop   = resp_axis_valid && resp_axis_ready;

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: header picks the burst direction, final beat returns to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_axis_valid && req_axis_tuser && hdr_len != '0)
                         state_d = req_axis_data[0] ? S_WRITE : S_READ;
            S_WRITE: if (wr_fire && last_beat) state_d = S_IDLE;
            S_READ:  if (rd_fire && last_beat) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: write bursts are a pass-through, reads throttle on FIFO room
    always_comb begin
        req_axis_ready = 1'b0;
        mem_valid      = 1'b0;
        mem_wen        = 1'b0;
        mem_addr       = addr_q;
        mem_wdata      = req_axis_data;
        case (state_q)
            S_IDLE:  req_axis_ready = rst_in;
            S_WRITE: begin
                mem_valid      = req_axis_valid;
                req_axis_ready = mem_ready && rst_in;
                mem_wen        = 1'b1;
            end
            S_READ:  mem_valid = room;
            default: ;
        endcase
    end

    assign resp_axis_valid = (fcnt_q != '0);
    assign resp_axis_data  = fdata_q[rptr_q];
    assign resp_axis_tuser = resp_axis_valid && flast_q[rptr_q];
    assign err_out         = err_q;

    // Burst bookkeeping, in-flight tags and the sticky error flag
    always_comb begin
        addr_d = addr_q;
        len_d  = len_q;
        beat_d = beat_q;
        err_d  = err_q;
        os_d   = os_q;
        tag_d  = tag_q;
        if (state_q == S_IDLE && req_axis_valid) begin
            if (req_axis_tuser) begin
                addr_d = ADDR_W'(req_axis_data[54:28]);
                len_d  = hdr_len;
                beat_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end
        if (wr_fire || rd_fire) begin
            addr_d = addr_q + ADDR_W'(1);
            beat_d = beat_q + LEN_W'(1);
        end
        if (wr_fire && req_axis_tuser) err_d = 1'b1;
        if (mem_rvalid && os_q == '0)  err_d = 1'b1;
        if (rsp_push) begin
            tag_d = tag_q >> 1;
            os_d  = os_q - CNT_W'(1);
        end
        if (rd_fire) begin
            tag_d[os_d] = last_beat;
            os_d        = os_d + CNT_W'(1);
        end
    end

    // Response FIFO pointers, occupancy and storage
    always_comb begin
        fdata_d = fdata_q;
        flast_d = flast_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        fcnt_d  = fcnt_q;
        if (rsp_push) begin
            fdata_d[wptr_q] = mem_rdata;
            flast_d[wptr_q] = tag_q[0];
            wptr_d          = ptr_inc(wptr_q);
        end
        if (rsp_pop) rptr_d = ptr_inc(rptr_q);
        if (rsp_push && !rsp_pop)      fcnt_d = fcnt_q + CNT_W'(1);
        else if (!rsp_push && rsp_pop) fcnt_d = fcnt_q - CNT_W'(1);
    end

    // Datapath registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            os_q    <= '0;
            tag_q   <= '0;
            flast_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) fdata_q[i] <= '0;
        end else begin
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            os_q    <= os_d;
            tag_q   <= tag_d;
            flast_q <= flast_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            fdata_q <= fdata_d;
        end
    end

endmodule

// File: tb/tb_axis_mem_responder.sv
// Randomized scoreboard bench for axis_mem_responder. Stimulus pushes the
// expected memory commands and response beats; a negedge monitor pops and
// compares them on every handshake. A behavioural memory answers reads in
// order with a configurable latency, data being a fixed function of address.
module tb_axis_mem_responder;

    localparam int DW = 128;
    localparam int AW = 27;
    localparam int RD = 4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          req_axis_valid = 1'b0, req_axis_tuser = 1'b0, req_axis_ready;
    logic [DW-1:0] req_axis_data = '0;
    logic          resp_axis_valid, resp_axis_tuser, resp_axis_ready = 1'b0;
    logic [DW-1:0] resp_axis_data;
    logic          mem_valid, mem_wen, mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          err_out;

    axis_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .RESP_DEPTH(RD)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_axis_valid(req_axis_valid), .req_axis_tuser(req_axis_tuser),
        .req_axis_data(req_axis_data), .req_axis_ready(req_axis_ready),
        .resp_axis_valid(resp_axis_valid), .resp_axis_tuser(resp_axis_tuser),
        .resp_axis_data(resp_axis_data), .resp_axis_ready(resp_axis_ready),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic wen; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
    typedef struct { logic [DW-1:0] data; logic last; } rsp_t;
    typedef struct { logic [AW-1:0] addr; int due; } pend_t;

    cmd_t  exp_cmd[$];
    rsp_t  exp_rsp[$];
    pend_t pend[$];
    cmd_t  ec;
    rsp_t  er;
    pend_t pp;

    int checks = 0, errors = 0;
    int cyc = 0, n_cmd = 0, n_rd = 0, lat = 3, last_due = 0, due_v = 0;
    int mrdy_mode = 1, rrdy_mode = 1;   // 0 low, 1 high, 2 random

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++)
            w[i*32 +: 32] = {5'd0, a} * 32'h9E3779B1 + 32'(i) * 32'h01000193;
        return w;
    endfunction

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: compare every memory command and response handshake
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (mem_valid && mem_ready) begin
                n_cmd++;
                if (!mem_wen) n_rd++;
                if (exp_cmd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: got addr %h wen %0b, expected no command", mem_addr, mem_wen);
                end else begin
                    ec = exp_cmd.pop_front();
                    chk("mem_wen", DW'(mem_wen), DW'(ec.wen));
                    chk("mem_addr", DW'(mem_addr), DW'(ec.addr));
                    if (ec.wen) chk("mem_wdata", mem_wdata, ec.data);
                end
                if (!mem_wen) begin
                    due_v = cyc + lat;
                    if (due_v < last_due) due_v = last_due;
                    last_due = due_v;
                    pend.push_back('{mem_addr, due_v});
                end
            end
            if (resp_axis_valid && resp_axis_ready) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got data %h, expected no response", resp_axis_data);
                end else begin
                    er = exp_rsp.pop_front();
                    chk("resp_data", resp_axis_data, er.data);
                    chk("resp_tuser", DW'(resp_axis_tuser), DW'(er.last));
                end
            end
        end
    end

    function automatic logic pick(input int mode);
        return (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    endfunction

    // Memory model and ready drivers
    always @(posedge clk_in) begin
        #1;
        mem_ready       = pick(mrdy_mode);
        resp_axis_ready = pick(rrdy_mode);
        mem_rvalid      = 1'b0;
        mem_rdata       = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            pp         = pend.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(pp.addr);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_beat(input logic tu, input logic [DW-1:0] d);
        int t = 0;
        req_axis_valid = 1'b1;
        req_axis_tuser = tu;
        req_axis_data  = d;
        forever begin
            @(negedge clk_in);
            if (req_axis_ready) break;
            t++;
            if (t > 1000) begin
                checks++; errors++;
                $display("FAIL beat_accept_timeout: got no ready, expected ready within 1000 cycles");
                break;
            end
        end
        @(posedge clk_in);
        #1;
        req_axis_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] make_hdr(input logic [AW-1:0] a, input int len, input logic wen);
        logic [DW-1:0] h;
        for (int i = 0; i < DW / 32; i++) h[i*32 +: 32] = $urandom;
        h[54:28] = a;
        h[27:1]  = 27'(len);
        h[0]     = wen;
        return h;
    endfunction

    task automatic rd_burst(input logic [AW-1:0] a, input int len);
        logic [AW-1:0] x;
        for (int i = 0; i < len; i++) begin
            x = a + AW'(i);
            exp_cmd.push_back('{1'b0, x, '0});
            exp_rsp.push_back('{mem_word(x), i == len - 1});
        end
        send_beat(1'b1, make_hdr(a, len, 1'b0));
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input int len);
        logic [DW-1:0] d;
        send_beat(1'b1, make_hdr(a, len, 1'b1));
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
            exp_cmd.push_back('{1'b1, a + AW'(i), d});
            if ($urandom_range(0, 2) == 0) idle(1);
            send_beat(1'b0, d);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || pend.size() != 0) && t < 3000) begin
            idle(1);
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s_drain: got %0d cmds %0d resps pending, expected 0", name, exp_cmd.size(), exp_rsp.size());
        end
        idle(3);
    endtask

    initial begin
        int base;
        idle(3);
        chk("rst_req_ready", DW'(req_axis_ready), '0);
        chk("rst_mem_valid", DW'(mem_valid), '0);
        chk("rst_resp_valid", DW'(resp_axis_valid), '0);
        chk("rst_resp_tuser", DW'(resp_axis_tuser), '0);
        chk("rst_err", DW'(err_out), '0);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("idle_req_ready", DW'(req_axis_ready), DW'(1));
        idle(1);

        // Simple read burst, latency 3
        lat = 3; mrdy_mode = 1; rrdy_mode = 1;
        rd_burst(27'h100, 4);
        drain("read4");
        chk("read4_err", DW'(err_out), '0);

        // Write burst wrapping the address space, mem_ready toggling
        mrdy_mode = 2;
        wr_burst(27'h7FFFFFE, 4);
        drain("write_wrap");

        // Response backpressure limits reads in flight
        mrdy_mode = 1; rrdy_mode = 0; lat = 2;
        base = n_rd;
        rd_burst(27'h200, 8);
        idle(30);
        chk("inflight_reads", DW'(n_rd - base), DW'(RD));
        @(negedge clk_in);
        chk("mem_valid_blocked", DW'(mem_valid), '0);
        idle(1);
        rrdy_mode = 1;
        drain("read8");
        chk("read8_total", DW'(n_rd - base), DW'(8));

        // Back-to-back reads with random response ready
        rrdy_mode = 2;
        rd_burst(27'h10, 4);
        rd_burst(27'h40, 4);
        drain("b2b");

        // Random mix of bursts
        for (int k = 0; k < 10; k++) begin
            lat = $urandom_range(1, 4);
            mrdy_mode = $urandom_range(1, 2);
            if ($urandom_range(0, 1) == 1) wr_burst(AW'($urandom), $urandom_range(1, 6));
            else                           rd_burst(AW'($urandom), $urandom_range(1, 6));
        end
        drain("random");
        chk("random_err", DW'(err_out), '0);

        // Stray data beat in idle, then zero-length header
        mrdy_mode = 1; rrdy_mode = 1;
        base = n_cmd;
        send_beat(1'b0, make_hdr(27'h55, 3, 1'b0));
        idle(2);
        chk("stray_err", DW'(err_out), DW'(1));
        send_beat(1'b1, make_hdr(27'h80, 0, 1'b0));
        idle(5);
        chk("len0_no_traffic", DW'(n_cmd - base), '0);
        @(negedge clk_in);
        chk("len0_idle_ready", DW'(req_axis_ready), DW'(1));
        idle(1);
        rd_burst(27'h900, 2);
        drain("after_err");
        chk("err_sticky", DW'(err_out), DW'(1));

        // Reset with two reads outstanding, late returns are dropped
        lat = 8;
        base = n_rd;
        rd_burst(27'h300, 4);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk_in);
            #2;
            if (n_rd - base >= 2) break;
        end
        rst_in = 1'b0;
        exp_cmd.delete();
        exp_rsp.delete();
        #1;
        chk("mid_rst_req_ready", DW'(req_axis_ready), '0);
        chk("mid_rst_mem_valid", DW'(mem_valid), '0);
        chk("mid_rst_resp_valid", DW'(resp_axis_valid), '0);
        chk("mid_rst_resp_tuser", DW'(resp_axis_tuser), '0);
        chk("mid_rst_err", DW'(err_out), '0);
        idle(2);
        rst_in = 1'b1;
        drain("late_rvalid");
        chk("late_reads_issued", DW'(n_rd - base), DW'(2));
        chk("late_err", DW'(err_out), DW'(1));
        chk("late_resp_valid", DW'(resp_axis_valid), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_mem_responder.md
AXIS_MEM_RESPONDER -- requirements
Module: axis_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the width of an AXIS beat and a memory word.
REQ-002 SHALL have parameter ADDR_W, default 27, meaning the beat-address width.
REQ-003 SHALL have parameter RESP_DEPTH, default 4, meaning the read-response FIFO depth and the maximum reads in flight.
REQ-004 SHALL have port clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports req_axis_valid, req_axis_tuser and req_axis_data, inputs of width 1, 1 and DATA_W, and req_axis_ready, output, 1, the request stream slave.
REQ-007 SHALL have ports resp_axis_valid, resp_axis_tuser and resp_axis_data, outputs of width 1, 1 and DATA_W, and resp_axis_ready, input, 1, the response stream master.
REQ-008 SHALL have ports mem_valid, mem_wen, mem_addr and mem_wdata, outputs of width 1, 1, ADDR_W and DATA_W, and mem_ready, input, 1, the memory command port.
REQ-009 SHALL have ports mem_rvalid, input, 1, and mem_rdata, input, DATA_W: in-order read return, no backpressure, latency of 1 or more cycles.
REQ-010 SHALL have port err_out, output, 1, a sticky protocol-error flag.

Function
REQ-011 Header beat format, SHALL: the beat has tuser=1; data[54:28] is the start address (beat units); data[27:1] is stream_length (beats); data[0] is wen. All other bits are ignored.
REQ-012 States SHALL be IDLE, WRITE and READ; handshakes complete only when valid and ready are both high.
REQ-013 IDLE SHALL hold req_axis_ready=1.
- Header accepted: latch addr, length and wen; go to WRITE if wen=1, else READ.
- stream_length=0: stay in IDLE; no memory traffic; no response.
- Beat accepted with tuser=0: discard it, set err_out, stay in IDLE.
REQ-014 WRITE SHALL behave as follows.
- Pass-through: mem_valid=req_axis_valid; req_axis_ready=mem_ready; mem_wen=1; mem_wdata=req_axis_data; mem_addr=cur_addr.
- Each accepted beat increments cur_addr (mod 2^ADDR_W) and the beat counter.
- The beat that completes stream_length returns the FSM to IDLE the next cycle.
- A tuser=1 beat in WRITE is consumed as data and sets err_out.
- Writes produce no response beats.
REQ-015 READ SHALL behave as follows.
- req_axis_ready=0; mem_wen=0; mem_addr=cur_addr.
- mem_valid=1 only while outstanding+fifo_count < RESP_DEPTH.
- Each accepted read increments cur_addr (wrapping), the beat counter and outstanding.
- After the final read is accepted, go to IDLE; the FIFO drains independently.
REQ-016 Each mem_rvalid SHALL push mem_rdata into the FIFO and decrement outstanding, with a last flag set on the final beat of its burst. A mem_rvalid while outstanding=0 SHALL be dropped and SHALL set err_out.
REQ-017 resp_axis_valid SHALL be FIFO not-empty; data and tuser SHALL come from the head entry; resp_axis_tuser=1 marks the last beat of a read burst.
REQ-018 Response latency SHALL be 1 cycle: an rvalid at cycle N is visible on resp_axis at N+1 if the FIFO was empty.
REQ-019 Simultaneous events SHALL be handled as follows.
- Push and pop in the same cycle: count unchanged, no loss.
- Read issue and rvalid in the same cycle: outstanding unchanged.
- FIFO overflow is impossible by REQ-015.
REQ-020 Response beats SHALL leave in command order across bursts; a new header MAY be accepted while earlier responses are still draining.
REQ-021 Outputs SHALL be glitch-free combinational functions of registered state and the current inputs; there are no combinational paths from resp_axis_ready to req_axis_ready.

Reset
REQ-022 On rst_in low, asynchronously: state=IDLE, counters=0, FIFO empty, outstanding=0, err_out=0. mem_valid, resp_axis_valid and resp_axis_tuser are 0. req_axis_ready is 0 while reset is asserted and 1 in IDLE after release.
REQ-023 Reset mid-burst SHALL abandon the burst. Data of reads in flight that returns after release is dropped per REQ-016 and flags err_out.

Verification
REQ-024 Scenario: read header addr=0x100, len=4, memory latency 3, resp_axis_ready=1 -> reads at 0x100..0x103; 4 response beats in order; tuser=1 only on the 4th; err_out=0.
REQ-025 Scenario: write header addr=0x7FFFFFE, len=4, 4 data beats with mem_ready toggling -> writes at 0x7FFFFFE, 0x7FFFFFF, 0x0, 0x1 with matching data; no response beats.
REQ-026 Scenario: read len=8 with resp_axis_ready=0 -> exactly 4 reads issued, then mem_valid=0; raising ready drains the FIFO and the remaining 4 reads issue; 8 beats arrive in order.
REQ-027 Scenario: data beat (tuser=0) in IDLE, then header len=0 -> err_out=1 and stays 1; no memory traffic; FSM remains in IDLE.
REQ-028 Scenario: back-to-back reads (len=4 at 0x10, then len=4 at 0x40) with random resp_axis_ready -> 8 beats, the first burst entirely before the second; tuser on beats 4 and 8.
REQ-029 Scenario: rst_in pulsed low with 2 reads outstanding, then 2 late rvalids -> outputs at reset values, FIFO stays empty, err_out=1.
